// File: rtl/baud_tick_ctrl_pkg.sv
// baud_ctrl_pkg: shared types and constants for the baud tick controller.
//   state_e : controller FSM states (STOP, RUN, PEND, LOAD)
//   DIV_MIN : smallest legal divisor; smaller offers are raised to this
package baud_ctrl_pkg;

    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2,
        LOAD = 2'd3
    } state_e;

    localparam int unsigned DIV_MIN = 2;

endpackage

// File: rtl/baud_tick_ctrl_if.sv
// baud_tick_ctrl_if: divisor-change handshake between software-side
// configuration logic (master) and the tick controller (slave).
//   cfg_valid : master offers cfg_div
//   cfg_div   : offered divisor, DIV_W bits
//   cfg_ready : controller can accept a divisor this cycle
interface baud_tick_ctrl_if #(
    parameter int DIV_W = 17
);
    logic             cfg_valid;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_ready;

    modport master (output cfg_valid, output cfg_div, input  cfg_ready);
    modport slave  (input  cfg_valid, input  cfg_div, output cfg_ready);
endinterface

// File: rtl/baud_tick_ctrl_tick_counter.sv
// tick_counter: modulo-(i_last+1) counter with clear and count-enable.
//   clk, rst_n : clock, async active-low reset
//   i_clr      : synchronous clear (wins over i_en), also kills the wrap pulse
//   i_en       : advance the count this cycle
//   i_last     : terminal count (N-1)
//   o_last     : combinational, the counter wraps on the coming edge
//   o_wrap     : registered one-cycle pulse, high in the cycle after a wrap
module tick_counter #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_last,
    output logic         o_last,
    output logic         o_wrap
);

    logic [W-1:0] r_cnt;
    logic         r_wrap;

    // Exposed so a downstream counter can advance on the same edge this
    // one wraps, keeping both registered pulses aligned.
    assign o_last = i_en && !i_clr && (r_cnt == i_last);
    assign o_wrap = r_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else if (i_clr) begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else if (i_en) begin
            r_cnt  <= (r_cnt == i_last) ? '0 : r_cnt + 1'b1;
            r_wrap <= (r_cnt == i_last);
        end else begin
            r_wrap <= 1'b0;
        end
    end

endmodule

// File: rtl/baud_tick_ctrl.sv
// baud_tick_ctrl: programmable oversample/bit tick generator with a
// run-time divisor-change handshake that never lands mid-frame.
//   clk, rst_n  : clock, async active-low reset
//   i_en        : run enable; low stops and clears tick generation
//   i_busy      : a TX or RX frame is in flight
//   cfg         : divisor handshake (baud_tick_ctrl_if.slave)
//   o_tick      : oversample tick, one-cycle pulse every o_div cycles
//   o_bit_tick  : one-cycle pulse on every OVS-th o_tick
//   o_div       : active divisor
//   o_pend      : a divisor is accepted but waiting for i_busy low
// Build option: BAUD_CTRL_BIT_TICK_EN enables the OVS bit sub-counter;
// without it o_bit_tick is tied 0.
module baud_tick_ctrl
    import baud_ctrl_pkg::*;
#(
    parameter int DIV_W   = 17,
    parameter int DEF_DIV = 100_000,
    parameter int OVS     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_busy,
    baud_tick_ctrl_if.slave  cfg,
    output logic             o_tick,
    output logic             o_bit_tick,
    output logic [DIV_W-1:0] o_div,
    output logic             o_pend
);

    state_e           r_state, w_nxt;
    logic [DIV_W-1:0] r_div, r_hold;
    logic [DIV_W-1:0] w_div_clamp, w_div_last;
    logic             w_xfer, w_clr, w_cnt_en, w_main_last;

    assign cfg.cfg_ready = (r_state == STOP) || (r_state == RUN);
    assign w_xfer        = cfg.cfg_valid && cfg.cfg_ready;
    assign w_div_clamp   = (cfg.cfg_div < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : cfg.cfg_div;
    assign w_div_last    = r_div - DIV_W'(1);
    assign o_div         = r_div;
    assign o_pend        = (r_state == PEND);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= STOP;
        else        r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            STOP: if (i_en) w_nxt = RUN;
            // A divisor accepted while disabling still goes through LOAD,
            // so it is applied rather than lost.
            RUN: begin
                if (w_xfer)     w_nxt = (i_busy && i_en) ? PEND : LOAD;
                else if (!i_en) w_nxt = STOP;
            end
            PEND: if (!i_busy || !i_en) w_nxt = LOAD;
            LOAD: w_nxt = i_en ? RUN : STOP;
            default: w_nxt = STOP;
        endcase
    end

    // Clearing on the edge that enters STOP/LOAD suppresses any wrap on
    // that edge; holding clear through LOAD restarts the count at the
    // edge the new divisor takes effect.
    assign w_clr    = (r_state == LOAD) || (w_nxt == STOP) || (w_nxt == LOAD);
    assign w_cnt_en = (r_state == RUN) || (r_state == PEND);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div  <= DIV_W'(DEF_DIV);
            r_hold <= DIV_W'(DEF_DIV);
        end else begin
            if (w_xfer) r_hold <= w_div_clamp;
            if (w_xfer && r_state == STOP) r_div <= w_div_clamp;
            else if (r_state == LOAD)      r_div <= r_hold;
        end
    end

    tick_counter #(.W(DIV_W)) u_div_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_clr),
        .i_en   (w_cnt_en),
        .i_last (w_div_last),
        .o_last (w_main_last),
        .o_wrap (o_tick)
    );

`ifdef BAUD_CTRL_BIT_TICK_EN
    localparam int BIT_W = (OVS > 1) ? $clog2(OVS) : 1;
    logic w_bit_last_unused;

    // Advances on the edge that raises o_tick, so the bit pulse lands in
    // the same cycle as the OVS-th oversample tick.
    tick_counter #(.W(BIT_W)) u_bit_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_clr),
        .i_en   (w_main_last),
        .i_last (BIT_W'(OVS - 1)),
        .o_last (w_bit_last_unused),
        .o_wrap (o_bit_tick)
    );
`else
    localparam int OVS_UNUSED = OVS;
    assign o_bit_tick = 1'b0;
`endif

endmodule

// File: tb/tb_baud_tick_ctrl.sv
module tb_baud_tick_ctrl;

    localparam int DIV_W = 17;
`ifdef BAUD_CTRL_BIT_TICK_EN
    localparam int BT = 1;
`else
    localparam int BT = 0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             i_en = 1'b0;
    logic             i_busy = 1'b0;
    logic             o_tick, o_bit_tick, o_pend;
    logic [DIV_W-1:0] o_div;

    baud_tick_ctrl_if #(.DIV_W(DIV_W)) cfg_if ();

    baud_tick_ctrl #(.DIV_W(DIV_W), .DEF_DIV(10), .OVS(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (i_en),
        .i_busy     (i_busy),
        .cfg        (cfg_if.slave),
        .o_tick     (o_tick),
        .o_bit_tick (o_bit_tick),
        .o_div      (o_div),
        .o_pend     (o_pend)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Cycles from the current reference edge to the next o_tick; bounded.
    task automatic tick_gap(input string tag, input int exp);
        int n = 0;
        do begin
            step();
            n++;
        end while (!o_tick && n < exp + 3);
        chk(tag, n, exp);
    endtask

    task automatic xfer(input int d);
        logic [DIV_W-1:0] dv;
        dv = d[DIV_W-1:0];
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div   = dv;
        step();
        cfg_if.cfg_valid = 1'b0;
    endtask

    initial begin
        int cnt;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_div   = '0;

        #12;
        chk("rst_div", int'(o_div), 10);
        chk("rst_tick", int'(o_tick), 0);
        chk("rst_btick", int'(o_bit_tick), 0);
        chk("rst_pend", int'(o_pend), 0);
        chk("rst_rdy", int'(cfg_if.cfg_ready), 1);

        step();
        rst_n = 1'b1;
        step();
        step();
        chk("stop_tick", int'(o_tick), 0);

        // Default divisor, bit tick on every 4th tick
        i_en = 1'b1;
        step();
        tick_gap("t1", 10);
        chk("bt1", int'(o_bit_tick), 0);
        tick_gap("t2", 10);
        tick_gap("t3", 10);
        tick_gap("t4", 10);
        chk("bt4", int'(o_bit_tick), BT);
        tick_gap("t5", 10);
        tick_gap("t6", 10);

        // Disable mid-period at count 6: no tick, phase restarts
        repeat (6) step();
        i_en = 1'b0;
        cnt = 0;
        repeat (12) begin
            step();
            cnt += int'(o_tick);
        end
        chk("off_ticks", cnt, 0);
        i_en = 1'b1;
        step();
        tick_gap("r1", 10);
        chk("rbt1", int'(o_bit_tick), 0);
        tick_gap("r2", 10);
        chk("rbt2", int'(o_bit_tick), 0);
        tick_gap("r3", 10);
        tick_gap("r4", 10);
        chk("rbt4", int'(o_bit_tick), BT);

        // Transfer in STOP applies at the transfer edge
        i_en = 1'b0;
        step();
        step();
        chk("rdy_stop", int'(cfg_if.cfg_ready), 1);
        xfer(5);
        chk("div_stop", int'(o_div), 5);
        chk("pend_stop", int'(o_pend), 0);
        i_en = 1'b1;
        step();
        tick_gap("s1", 5);
        tick_gap("s2", 5);

        // Transfer in RUN, not busy: one-cycle LOAD
        xfer(10);
        chk("rdy_load", int'(cfg_if.cfg_ready), 0);
        chk("div_pre", int'(o_div), 5);
        chk("tick_load", int'(o_tick), 0);
        step();
        chk("div_load", int'(o_div), 10);
        chk("rdy_run", int'(cfg_if.cfg_ready), 1);
        tick_gap("l1", 10);

        // Transfer while busy: held until busy drops
        i_busy = 1'b1;
        xfer(4);
        chk("pend_on", int'(o_pend), 1);
        chk("rdy_pend", int'(cfg_if.cfg_ready), 0);
        chk("div_pend", int'(o_div), 10);
        tick_gap("p1", 9);
        tick_gap("p2", 10);
        chk("pend_hold", int'(o_pend), 1);
        i_busy = 1'b0;
        step();
        chk("div_in_load", int'(o_div), 10);
        step();
        chk("div_new", int'(o_div), 4);
        chk("pend_off", int'(o_pend), 0);
        tick_gap("n1", 4);
        tick_gap("n2", 4);

        // Divisor 0 is raised to 2
        xfer(0);
        step();
        chk("div_clamp", int'(o_div), 2);
        tick_gap("c1", 2);
        tick_gap("c2", 2);

        // Reset while a divisor is pending discards it
        i_busy = 1'b1;
        xfer(7);
        chk("pend7", int'(o_pend), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_div", int'(o_div), 10);
        chk("arst_pend", int'(o_pend), 0);
        chk("arst_rdy", int'(cfg_if.cfg_ready), 1);
        chk("arst_tick", int'(o_tick), 0);
        step();
        step();
        i_busy = 1'b0;
        rst_n = 1'b1;
        step();
        tick_gap("rst_t1", 10);
        chk("rst_div_after", int'(o_div), 10);
        tick_gap("rst_t2", 10);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/baud_tick_ctrl.md
# baud_tick_ctrl

Programmable tick controller for the UART FIFO path: produces the single-cycle oversample tick and bit tick consumed by the UART TX and RX engines. A divisor-change handshake allows the baud rate to be changed at run time. New divisors are held off while a frame is in flight (`i_busy`), so a frame never straddles two rates. Replaces fixed-count tick generation wherever the rate must be software-selectable.

## Interface
- `DIV_W`, 17, width of divisor and counter (covers 100_000).
- `DEF_DIV`, 100_000, active divisor after reset.
- `OVS`, 16, oversample ticks per bit tick.
- `clk` input 1: single clock, all logic on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `i_en` input 1: run enable; low stops and clears tick generation.
- `i_busy` input 1: TX or RX frame in progress (OR of both engines).
- `cfg_valid` input 1: new divisor offered.
- `cfg_div` input DIV_W: offered divisor.
- `cfg_ready` output 1: controller can accept a divisor.
- `o_tick` output 1: oversample tick, one-cycle pulse.
- `o_bit_tick` output 1: bit tick, one-cycle pulse.
- `o_div` output DIV_W: currently active divisor.
- `o_pend` output 1: divisor accepted but not yet applied.

## Operation
- FSM states:
  - `STOP`: `i_en` low.
  - `RUN`: counting.
  - `PEND`: accepted divisor waiting for `i_busy` low.
  - `LOAD`: one cycle; applies the held divisor.
- Handshake:
  - Transfer occurs on an edge where `cfg_valid && cfg_ready`.
  - `cfg_ready` is 1 in `STOP` and `RUN`, 0 in `PEND` and `LOAD`.
  - `cfg_div` is captured into a holding register at the transfer edge.
- Divisor clamp: values below `DIV_MIN` (2) are replaced by 2 at capture.
- `STOP`:
  - Counters are held at 0 and `o_tick`/`o_bit_tick` are 0.
  - An accepted divisor is written to `o_div` on the transfer edge (no `PEND`).
  - `i_en` high moves the FSM to `RUN`.
- `RUN`:
  - The counter counts 0..`o_div`-1 and wraps to 0.
  - `o_tick` is registered and is 1 in the cycle after the counter wraps.
  - On transfer with `i_busy` low, go to `LOAD`; with `i_busy` high, go to `PEND`.
- `PEND`:
  - Counting continues at the old rate and `o_pend`=1.
  - `i_busy` low moves the FSM to `LOAD`.
  - `i_en` low moves the FSM to `LOAD`; the divisor is applied, then the FSM goes to `STOP`.
- `LOAD`:
  - `o_div` takes the held divisor; counter and bit sub-counter clear to 0; `o_pend` clears.
  - No tick is emitted in this cycle; a wrap coinciding with `LOAD` is dropped.
  - Next state is `RUN` if `i_en`=1, else `STOP`.
- `i_en` low in `RUN` moves the FSM to `STOP` on the next edge; the counter clears and no partial-period tick is emitted.
- Bit sub-counter:
  - Counts `o_tick` pulses modulo `OVS`.
  - `o_bit_tick` is 1 in the same cycle as every `OVS`-th `o_tick`.
- Counter arithmetic is unsigned `DIV_W`-bit; the compare uses `o_div-1`, and no overflow is possible because `o_div`≥2.

## Timing
- Reset values:
  - State `STOP`, counters 0.
  - `o_div`=`DEF_DIV`, `o_tick`=0, `o_bit_tick`=0, `o_pend`=0.
  - `cfg_ready`=1, holding register=`DEF_DIV`.
- Reset asserted mid-operation restores all reset values asynchronously; a pending divisor is discarded.
- First `o_tick` is exactly `o_div` cycles after the first edge with `i_en`=1 sampled in `STOP`. Subsequent ticks follow every `o_div` cycles.
- After `LOAD`, the first tick at the new rate is `o_div`(new) cycles after the `LOAD` edge.
- Transfer-to-apply latency:
  - In `STOP`: 0 cycles; `o_div` updates at the transfer edge.
  - In `RUN` with `i_busy` low: 1 cycle (via `LOAD`).
  - In `PEND`: 1 cycle after `i_busy` falls.
- All outputs are registered; `cfg_ready` is decoded from registered state only.

## Configuration
- `BAUD_CTRL_BIT_TICK_EN` defined: the `OVS` sub-counter is present and `o_bit_tick` behaves as specified.
- Not defined: the sub-counter is removed, `o_bit_tick` is tied 0, and `OVS` is unused. All other behaviour is identical.

## Structure
- Package `baud_ctrl_pkg` holds:
  - the state enumeration (`STOP`, `RUN`, `PEND`, `LOAD`);
  - `DIV_MIN`=2.
- Sub-module `tick_counter`: a modulo-N counter with clear and count-enable, emitting a registered wrap pulse.
  - Instantiated once for the divisor (N=`o_div`).
  - Instantiated once for the bit sub-counter (N=`OVS`), only under `BAUD_CTRL_BIT_TICK_EN`.

## Test plan
- Reset then `i_en`=1 with `DEF_DIV` overridden to 10 and `OVS`=4 → `o_tick` every 10 cycles, first at cycle 10; `o_bit_tick` coincides with every 4th tick.
- In `STOP`, transfer `cfg_div`=5 → `o_div`=5 at the transfer edge; after `i_en`=1, ticks every 5 cycles.
- In `RUN` (div 10), `i_busy`=1, transfer `cfg_div`=4:
  - `cfg_ready`=0 and `o_pend`=1, ticks continue every 10 cycles.
  - `i_busy` falls → `LOAD`, then ticks every 4 cycles starting 4 cycles after `LOAD`.
- Transfer `cfg_div`=0 → `o_div`=2; ticks every 2 cycles.
- Deassert `i_en` mid-period (counter=6 of 10) → no tick that period. Re-enable → first tick 10 cycles later, and `o_bit_tick` phase restarts.
- Assert `rst_n`=0 while in `PEND` with held div 7 → immediately `o_div`=`DEF_DIV`, `o_pend`=0, `cfg_ready`=1, and the held value is not applied after release.
